// File: rtl/dds_wave.sv
// dds_wave: phase-accumulator waveform generator (sine LUT, square, saw, triangle) with valid/ready output.
// Defining DDS_WAVE_AMPLITUDE_EN adds the amp_i port and an unsigned gain stage on the sample.
module dds_wave #(
  parameter int width_p       = 12,
  parameter int phase_width_p = 24,
  parameter int lut_log2_p    = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      en_i,
  input  logic [phase_width_p-1:0]  tune_i,
  input  logic [1:0]                wave_sel_i,
  input  logic                      sync_i,
  input  logic                      ready_i,
`ifdef DDS_WAVE_AMPLITUDE_EN
  input  logic [width_p-1:0]        amp_i,
`endif
  output logic signed [width_p-1:0] data_o,
  output logic                      valid_o
);

  localparam int lutDepth_lp = 2 ** lut_log2_p;
  localparam int peak_lp     = 2 ** (width_p - 1) - 1;

  localparam logic signed [width_p-1:0] c_posPeak = {1'b0, {(width_p-1){1'b1}}};
  localparam logic signed [width_p-1:0] c_negPeak = {1'b1, {(width_p-2){1'b0}}, 1'b1};

  // Rounded sine entry, evaluated only at elaboration to fill the table.
  function automatic logic signed [width_p-1:0] sineEntry(input int idx);
    real angle;
    real scaled;
    int  rounded;
    angle  = 2.0 * 3.14159265358979323846 * real'(idx) / real'(lutDepth_lp);
    scaled = real'(peak_lp) * $sin(angle);
    rounded = (scaled >= 0.0) ? $rtoi(scaled + 0.5) : -$rtoi(0.5 - scaled);
    return rounded[width_p-1:0];
  endfunction

  logic signed [width_p-1:0] w_lut [lutDepth_lp];

  for (genvar gi = 0; gi < lutDepth_lp; gi++) begin : g_lut
    localparam logic signed [width_p-1:0] c_entry = sineEntry(gi);
    assign w_lut[gi] = c_entry;
  end

  logic [phase_width_p-1:0] r_phase;
  logic signed [width_p-1:0] r_data;
  logic                      r_valid;

  logic                      w_advance;
  logic [width_p-1:0]        w_p;
  logic [lut_log2_p-1:0]     w_lutIdx;
  logic [width_p-2:0]        w_q;
  logic signed [width_p-1:0] w_wave;
  logic signed [width_p-1:0] w_sample;

  assign w_advance = en_i && (!r_valid || ready_i);

  // A hard-sync sample is taken from phase zero rather than the accumulator.
  assign w_p      = sync_i ? '0 : r_phase[phase_width_p-1 -: width_p];
  assign w_lutIdx = sync_i ? '0 : r_phase[phase_width_p-1 -: lut_log2_p];
  assign w_q      = w_p[width_p-1] ? ~w_p[width_p-2:0] : w_p[width_p-2:0];

  always_comb begin
    w_wave = w_lut[w_lutIdx];
    case (wave_sel_i)
      2'd1:    w_wave = w_p[width_p-1] ? c_negPeak : c_posPeak;
      2'd2:    w_wave = {~w_p[width_p-1], w_p[width_p-2:0]};
      2'd3:    w_wave = {~w_q[width_p-2], w_q[width_p-3:0], 1'b0};
      default: w_wave = w_lut[w_lutIdx];
    endcase
  end

`ifdef DDS_WAVE_AMPLITUDE_EN
  logic signed [2*width_p-1:0] w_product;

  // Product of a signed wave and an unsigned gain fits 2*width_p bits; the upper half is the floor shift.
  assign w_product = w_wave * $signed({1'b0, amp_i});
  assign w_sample  = w_product[2*width_p-1:width_p];
`else
  assign w_sample = w_wave;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_phase <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_advance) begin
      r_phase <= sync_i ? tune_i : r_phase + tune_i;
      r_data  <= w_sample;
      r_valid <= 1'b1;
    end else if (ready_i && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign data_o  = r_data;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_dds_wave.sv
// tb_dds_wave: directed and randomized checks of dds_wave against an arithmetic reference model.
// Build with DDS_WAVE_AMPLITUDE_EN defined to also exercise the gain stage.
module tb_dds_wave;

  typedef logic signed [31:0] word_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              en = 1'b0;
  logic [15:0]       tune = '0;
  logic [1:0]        sel = '0;
  logic              sync = 1'b0;
  logic              ready = 1'b0;
  logic signed [11:0] data;
  logic              valid;
`ifdef DDS_WAVE_AMPLITUDE_EN
  logic [11:0]       amp = 12'hFFF;
`endif

  int total = 0;
  int bad = 0;

  int    mPhase = 0;
  word_t mData = 0;
  word_t mValid = 0;
  word_t samples[$];

  dds_wave #(
    .width_p(12),
    .phase_width_p(16),
    .lut_log2_p(8)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .en_i(en),
    .tune_i(tune),
    .wave_sel_i(sel),
    .sync_i(sync),
    .ready_i(ready),
`ifdef DDS_WAVE_AMPLITUDE_EN
    .amp_i(amp),
`endif
    .data_o(data),
    .valid_o(valid)
  );

  always #5 clk = ~clk;

  // Applies the optional gain to an unscaled wave value (identity in the default build).
  function automatic word_t gainOf(input word_t w);
`ifdef DDS_WAVE_AMPLITUDE_EN
    return (w * word_t'(amp)) >>> 12;
`else
    return w;
`endif
  endfunction

  function automatic word_t waveModel(input int phase, input int s);
    int  p;
    int  q;
    real v;
    p = phase / 16;
    case (s)
      0: begin
        v = 2047.0 * $sin(2.0 * 3.14159265358979323846 * real'(phase / 256) / 256.0);
        return (v >= 0.0) ? word_t'($rtoi(v + 0.5)) : -word_t'($rtoi(0.5 - v));
      end
      1: return (p < 2048) ? 2047 : -2047;
      2: return p - 2048;
      default: begin
        q = (p < 2048) ? p : 4095 - p;
        return 2 * q - 2048;
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input word_t observed, input word_t expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  // Drives one cycle of inputs, advances the clock, updates the model and compares outputs.
  task automatic applyStimulus(input logic rst, input logic e, input logic rdy, input logic syn,
                               input logic [1:0] s, input logic [15:0] t);
    bit adv;
    reset = rst; en = e; ready = rdy; sync = syn; sel = s; tune = t;
    adv = e && (mValid == 0 || rdy);
    @(posedge clk);
    #1;
    if (rst) begin
      mPhase = 0; mData = 0; mValid = 0;
    end else if (adv) begin
      mData  = gainOf(waveModel(syn ? 0 : mPhase, int'(s)));
      mPhase = syn ? int'(t) : (mPhase + int'(t)) % 65536;
      mValid = 1;
      samples.push_back(word_t'(data));
    end else if (rdy && mValid == 1) begin
      mValid = 0;
    end
    checkOutput("valid", word_t'({31'b0, valid}), mValid);
    checkOutput("data", word_t'(data), mData);
  endtask

  task automatic runFor(input int n, input logic syn, input logic [1:0] s, input logic [15:0] t);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b1, syn, s, t);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
    samples.delete();
  endtask

  initial begin
    doReset();
    checkOutput("reset_valid", word_t'({31'b0, valid}), 0);
    checkOutput("reset_data", word_t'(data), 0);

    runFor(65, 1'b0, 2'd0, 16'h0400);
    checkOutput("sine_s0", samples[0], gainOf(0));
    checkOutput("sine_s16", samples[16], gainOf(2047));
    checkOutput("sine_s32", samples[32], gainOf(0));
    checkOutput("sine_s48", samples[48], gainOf(-2047));
    checkOutput("sine_s64", samples[64], gainOf(0));

    doReset();
    runFor(17, 1'b0, 2'd2, 16'h1000);
    for (int k = 0; k < 16; k++) checkOutput($sformatf("saw_s%0d", k), samples[k], gainOf(-2048 + 256 * k));
    checkOutput("saw_wrap", samples[16], gainOf(-2048));

    doReset();
    runFor(4, 1'b0, 2'd1, 16'h8000);
    runFor(4, 1'b0, 2'd3, 16'h8000);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("square_s%0d", k), samples[k], gainOf((k % 2 == 0) ? 2047 : -2047));
      checkOutput($sformatf("tri_s%0d", k), samples[k + 4], gainOf((k % 2 == 0) ? -2048 : 2046));
    end

    doReset();
    runFor(3, 1'b0, 2'd2, 16'h1000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'($urandom), 1'b0, 1'($urandom), 2'($urandom), 16'($urandom));
      checkOutput("hold_data", word_t'(data), gainOf(-1536));
      checkOutput("hold_valid", word_t'({31'b0, valid}), 1);
    end
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd2, 16'h1000);
    checkOutput("hold_successor", word_t'(data), gainOf(-1280));

    doReset();
    runFor(10, 1'b0, 2'd0, 16'h0400);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h0400);
    checkOutput("sync_zero", word_t'(data), gainOf(0));
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0400);
    checkOutput("sync_restart", word_t'(data), gainOf(201));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0400);
    checkOutput("idle_drop_valid", word_t'({31'b0, valid}), 0);
    runFor(3, 1'b0, 2'd1, 16'h3000);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 16'h3000);
    checkOutput("midreset_valid", word_t'({31'b0, valid}), 0);
    checkOutput("midreset_data", word_t'(data), 0);

`ifdef DDS_WAVE_AMPLITUDE_EN
    doReset();
    amp = 12'h800;
    runFor(17, 1'b0, 2'd0, 16'h0400);
    checkOutput("gain_peak", samples[16], 1023);
    amp = 12'h000;
    samples.delete();
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'($urandom), 16'($urandom));
    foreach (samples[i]) checkOutput("gain_zero", samples[i], 0);
`endif

    for (int i = 0; i < 400; i++) begin
`ifdef DDS_WAVE_AMPLITUDE_EN
      amp = 12'($urandom);
`endif
      applyStimulus(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) < 8),
                    1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0),
                    2'($urandom), 16'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_wave.md
DDS_WAVE -- requirements
Module: dds_wave

Interface
REQ-001 SHALL have parameter width_p, default 12: output sample width, signed two's complement.
REQ-002 SHALL have parameter phase_width_p, default 24: phase accumulator width; legal only when phase_width_p >= width_p and phase_width_p >= lut_log2_p.
REQ-003 SHALL have parameter lut_log2_p, default 8: log2 of the sine LUT depth (N = 2^lut_log2_p entries, full period).
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port en_i, input, 1: enables sample generation.
REQ-007 SHALL have port tune_i, input, phase_width_p: phase increment (frequency = tune_i * f_sample / 2^phase_width_p).
REQ-008 SHALL have port wave_sel_i, input, 2: waveform select, where 0 is sine, 1 is square, 2 is saw and 3 is triangle.
REQ-009 SHALL have port sync_i, input, 1: hard-sync, which restarts the phase at 0.
REQ-010 SHALL have port ready_i, input, 1: the downstream consumer accepts data_o.
REQ-011 SHALL have port data_o, output, width_p: registered signed sample.
REQ-012 SHALL have port valid_o, output, 1: data_o holds an unconsumed sample.

Function
REQ-013 SHALL define advance = en_i && (!valid_o || ready_i); an advance is the only event that changes phase_r, data_o or valid_o to 1.
REQ-014 SHALL, on advance with sync_i=0, set data_o <= wave(phase_r) and phase_r <= phase_r + tune_i, with the sum wrapping modulo 2^phase_width_p.
REQ-015 SHALL, on advance with sync_i=1, set data_o <= wave(0) and phase_r <= tune_i; sync_i is ignored when there is no advance.
REQ-016 SHALL, on advance, set valid_o <= 1.
REQ-017 SHALL, when !en_i && ready_i && valid_o, set valid_o <= 0 and hold data_o and phase_r.
REQ-018 SHALL hold data_o, valid_o and phase_r unchanged while valid_o=1 && ready_i=0, whatever the values of en_i, tune_i, wave_sel_i and sync_i; no sample is skipped or duplicated.
REQ-019 SHALL produce the first valid_o=1 one cycle after the first cycle with en_i=1.
REQ-020 SHALL sample wave_sel_i and tune_i only on an advance cycle; a change in either affects the sample produced on that advance.
REQ-021 SHALL use p = phase_r[phase_width_p-1 -: width_p] and M = 2^(width_p-1)-1 in the waveform definitions.
REQ-022 SHALL compute sine as LUT[phase_r[phase_width_p-1 -: lut_log2_p]], with LUT[i] = round(M*sin(2*pi*i/N)) computed at elaboration, so that LUT[0]=LUT[N/2]=0, LUT[N/4]=M and LUT[3N/4]=-M.
REQ-023 SHALL compute square as +M when p[width_p-1]=0 and -M otherwise.
REQ-024 SHALL compute saw as p with its MSB inverted, read as signed, giving a range of -2^(width_p-1) to 2^(width_p-1)-1.
REQ-025 SHALL compute triangle as 2*q - 2^(width_p-1), where q = p[width_p-2:0], bitwise inverted when p[width_p-1]=1.
REQ-026 SHALL register data_o and SHALL NOT drive it combinationally from any input.

Reset
REQ-027 SHALL, while reset_i=1 at a clock edge, set phase_r=0, data_o=0 and valid_o=0, overriding any simultaneous advance.
REQ-028 SHALL discard a pending unconsumed sample when reset is asserted mid-stream; valid_o is 0 on the next cycle.

Configuration
REQ-029 SHALL, when the macro DDS_WAVE_AMPLITUDE_EN is defined, add port amp_i (input, width_p, unsigned gain) and set data_o = (wave * {1'b0, amp_i}) >>> width_p, computed at full product width with an arithmetic floor shift and sampled on advance.
REQ-030 SHALL, when DDS_WAVE_AMPLITUDE_EN is not defined, have no amp_i port and no multiplier, and SHALL set data_o = wave unscaled.

Verification (width_p=12, phase_width_p=16, lut_log2_p=8)
REQ-031 SHALL cover sine: reset, then en_i=1, ready_i=1, tune_i=0x0400, sel=0 -> samples 0, 16, 32 and 48 equal 0, 2047, 0 and -2047, and sample 64 equals sample 0.
REQ-032 SHALL cover saw and wrap: sel=2, tune_i=0x1000 -> -2048, -1792, -1536, ..., 1792, then -2048 again at sample 16.
REQ-033 SHALL cover square and triangle: sel=1, tune_i=0x8000 -> 2047, -2047 alternating; sel=3, tune_i=0x8000 -> -2048, 2046 alternating.
REQ-034 SHALL cover backpressure: hold ready_i=0 for 5 cycles while valid_o=1 -> data_o stable for all 5 cycles, and the next accepted sample is the successor with no skip.
REQ-035 SHALL cover sync and reset: sync_i=1 on an advance mid-stream with sel=0 -> data_o=0 and the sequence restarts; reset_i mid-stream -> valid_o=0 and data_o=0 on the next cycle.
REQ-036 SHALL cover gain when DDS_WAVE_AMPLITUDE_EN is defined: amp_i=0x800 with the sine peak sample -> data_o=1023; amp_i=0 -> every sample equals 0.
